// File: rtl/pipe_pkg.sv
// Shared MEM/WB pipeline types and defaults.
// Holds the writeback lane layout, the lane limit and the occupancy encoding helper.
package pipe_pkg;

    localparam int WB_MAX_LANES = 4;
    localparam int WB_RD_W      = 5;
    localparam int WB_DATA_W    = 64;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_to_reg;
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] wdata;
    } wb_lane_t;

    // The skid entry is only ever occupied behind a valid output entry.
    function automatic logic [1:0] occ_encode(input logic main_vld, input logic skid_vld);
        return {skid_vld, main_vld & ~skid_vld};
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One writeback bundle register with load and clear enables.
// Latency: 1 cycle from load to q. Backpressure: none, the owner decides when to load.
// clear has priority over load and returns every field to zero.
module wb_slot
    import pipe_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int RD_W   = WB_RD_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     clear,
    input  logic [LANES-1:0]         d_reg_write,
    input  logic [LANES-1:0]         d_mem_to_reg,
    input  logic [LANES*RD_W-1:0]    d_rd,
    input  logic [LANES*DATA_W-1:0]  d_wdata,
    output logic [LANES-1:0]         q_reg_write,
    output logic [LANES-1:0]         q_mem_to_reg,
    output logic [LANES*RD_W-1:0]    q_rd,
    output logic [LANES*DATA_W-1:0]  q_wdata
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg_write  <= '0;
            q_mem_to_reg <= '0;
            q_rd         <= '0;
            q_wdata      <= '0;
        end else if (clear) begin
            q_reg_write  <= '0;
            q_mem_to_reg <= '0;
            q_rd         <= '0;
            q_wdata      <= '0;
        end else if (load) begin
            q_reg_write  <= d_reg_write;
            q_mem_to_reg <= d_mem_to_reg;
            q_rd         <= d_rd;
            q_wdata      <= d_wdata;
        end
    end

endmodule

// File: rtl/mem_wb_ctrl_stage.sv
// MEM/WB writeback stage: registers LANES retire slots with valid/ready and synchronous flush.
// Latency: 1 cycle. Backpressure: in_ready = !out_valid || out_ready, or with WB_SKID_EN a
// registered !skid-full (2-entry skid buffer).
module mem_wb_ctrl_stage
    import pipe_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int RD_W   = WB_RD_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_reg_write,
    input  logic [LANES-1:0]         in_mem_to_reg,
    input  logic [LANES*RD_W-1:0]    in_rd,
    input  logic [LANES*DATA_W-1:0]  in_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_reg_write,
    output logic [LANES-1:0]         out_mem_to_reg,
    output logic [LANES*RD_W-1:0]    out_rd,
    output logic [LANES*DATA_W-1:0]  out_wdata,
    output logic [1:0]               occupancy
);

    logic                    main_vld;
    logic                    main_vld_d;
    logic                    main_load;
    logic                    main_clear;
    logic                    skid_vld;
    logic                    acc_in;
    logic                    acc_out;
    logic [LANES-1:0]        main_d_reg_write;
    logic [LANES-1:0]        main_d_mem_to_reg;
    logic [LANES*RD_W-1:0]   main_d_rd;
    logic [LANES*DATA_W-1:0] main_d_wdata;

    assign acc_out = main_vld && out_ready;
    assign acc_in  = in_valid && in_ready && !flush;

`ifdef WB_SKID_EN
    logic                    skid_vld_d;
    logic                    skid_load;
    logic                    skid_clear;
    logic                    main_from_skid;
    logic [LANES-1:0]        skid_reg_write;
    logic [LANES-1:0]        skid_mem_to_reg;
    logic [LANES*RD_W-1:0]   skid_rd;
    logic [LANES*DATA_W-1:0] skid_wdata;

    // Depends only on a flop, so out_ready never reaches in_ready combinationally.
    assign in_ready = !skid_vld;

    always_comb begin
        main_vld_d     = main_vld;
        skid_vld_d     = skid_vld;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (skid_vld) begin
            // in_ready is low here, so the skid entry drains before any new input.
            if (acc_out) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clear     = 1'b1;
                skid_vld_d     = 1'b0;
            end
        end else if (acc_in && (!main_vld || acc_out)) begin
            main_load  = 1'b1;
            main_vld_d = 1'b1;
        end else if (acc_in) begin
            skid_load  = 1'b1;
            skid_vld_d = 1'b1;
        end else if (acc_out) begin
            main_clear = 1'b1;
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_vld <= 1'b0;
        end else begin
            skid_vld <= skid_vld_d;
        end
    end

    assign main_d_reg_write  = main_from_skid ? skid_reg_write  : in_reg_write;
    assign main_d_mem_to_reg = main_from_skid ? skid_mem_to_reg : in_mem_to_reg;
    assign main_d_rd         = main_from_skid ? skid_rd         : in_rd;
    assign main_d_wdata      = main_from_skid ? skid_wdata      : in_wdata;

    wb_slot #(
        .LANES  (LANES),
        .RD_W   (RD_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk          (clk),
        .reset        (reset),
        .load         (skid_load),
        .clear        (skid_clear),
        .d_reg_write  (in_reg_write),
        .d_mem_to_reg (in_mem_to_reg),
        .d_rd         (in_rd),
        .d_wdata      (in_wdata),
        .q_reg_write  (skid_reg_write),
        .q_mem_to_reg (skid_mem_to_reg),
        .q_rd         (skid_rd),
        .q_wdata      (skid_wdata)
    );
`else
    assign skid_vld = 1'b0;
    assign in_ready = !main_vld || out_ready;

    // A simultaneous in/out transfer simply overwrites the held bundle.
    always_comb begin
        main_vld_d = main_vld;
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (flush) begin
            main_vld_d = 1'b0;
            main_clear = 1'b1;
        end else if (acc_in) begin
            main_load  = 1'b1;
            main_vld_d = 1'b1;
        end else if (acc_out) begin
            main_clear = 1'b1;
            main_vld_d = 1'b0;
        end
    end

    assign main_d_reg_write  = in_reg_write;
    assign main_d_mem_to_reg = in_mem_to_reg;
    assign main_d_rd         = in_rd;
    assign main_d_wdata      = in_wdata;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_vld <= 1'b0;
        end else begin
            main_vld <= main_vld_d;
        end
    end

    // The output slot is cleared whenever it empties, so its reg_write bits
    // can only be set while out_valid is high.
    wb_slot #(
        .LANES  (LANES),
        .RD_W   (RD_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk          (clk),
        .reset        (reset),
        .load         (main_load),
        .clear        (main_clear),
        .d_reg_write  (main_d_reg_write),
        .d_mem_to_reg (main_d_mem_to_reg),
        .d_rd         (main_d_rd),
        .d_wdata      (main_d_wdata),
        .q_reg_write  (out_reg_write),
        .q_mem_to_reg (out_mem_to_reg),
        .q_rd         (out_rd),
        .q_wdata      (out_wdata)
    );

    assign out_valid = main_vld;
    assign occupancy = occ_encode(main_vld, skid_vld);

endmodule

// File: tb/tb_mem_wb_ctrl_stage.sv
// Self-checking bench for mem_wb_ctrl_stage with LANES=2; reference model is an ordered queue
// bounded by the stage capacity (1, or 2 when WB_SKID_EN is defined).
module tb_mem_wb_ctrl_stage;

    localparam int LANES  = 2;
    localparam int RD_W   = 5;
    localparam int DATA_W = 64;
`ifdef WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [LANES-1:0]        rw;
        logic [LANES-1:0]        m2r;
        logic [LANES*RD_W-1:0]   rd;
        logic [LANES*DATA_W-1:0] wd;
    } bnd_t;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic flush     = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    bnd_t cur       = '0;

    logic                    in_ready;
    logic                    out_valid;
    logic [LANES-1:0]        out_reg_write;
    logic [LANES-1:0]        out_mem_to_reg;
    logic [LANES*RD_W-1:0]   out_rd;
    logic [LANES*DATA_W-1:0] out_wdata;
    logic [1:0]              occupancy;
    bnd_t                    obs;

    int n_checks = 0;
    int n_pass   = 0;
    bnd_t mq[$];

    assign obs = {out_reg_write, out_mem_to_reg, out_rd, out_wdata};

    always #5 clk = ~clk;

    mem_wb_ctrl_stage #(
        .LANES  (LANES),
        .RD_W   (RD_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_reg_write   (cur.rw),
        .in_mem_to_reg  (cur.m2r),
        .in_rd          (cur.rd),
        .in_wdata       (cur.wd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_reg_write  (out_reg_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_rd         (out_rd),
        .out_wdata      (out_wdata),
        .occupancy      (occupancy)
    );

    function automatic bnd_t rnd_bundle();
        bnd_t b;
        b.rw  = LANES'($urandom);
        b.m2r = LANES'($urandom);
        b.rd  = (LANES*RD_W)'($urandom);
        b.wd  = {$urandom, $urandom, $urandom, $urandom};
        return b;
    endfunction

    // Whether the stage may take a bundle, from the capacity rule alone.
    function automatic bit m_ready();
`ifdef WB_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || (out_ready == 1'b1);
`endif
    endfunction

    // Advance one clock and apply the same transfers to the model queue.
    task automatic tick();
        bit ai;
        bit ao;
        bnd_t b;
        ai = in_valid && m_ready() && !flush;
        ao = (mq.size() != 0) && out_ready;
        b  = cur;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (ao) void'(mq.pop_front());
            if (ai) mq.push_back(b);
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
        n_checks++; if (obs !== '0) $display("FAIL reset_fields: got %h want 0", obs); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bnd_t b;
        b    = rnd_bundle();
        b.rw = 2'b11;
        b.rd = {5'd7, 5'd3};
        cur = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %0b want 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %0b want 1", out_valid); else n_pass++;
        n_checks++; if (obs !== b) $display("FAIL basic_fields: got %h want %h", obs, b); else n_pass++;
        n_checks++; if (occupancy !== 2'd1) $display("FAIL basic_occ1: got %0d want 1", occupancy); else n_pass++;
        tick();
        n_checks++; if (occupancy !== 2'd0) $display("FAIL basic_occ0: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (out_reg_write !== 2'b00) $display("FAIL basic_rw_after: got %b want 00", out_reg_write); else n_pass++;
    endtask

    task automatic test_no_early_write();
        bnd_t b;
        b    = rnd_bundle();
        b.rw = 2'b11;
        cur = b; in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            #1;
            n_checks++; if (out_reg_write !== 2'b00 || out_valid !== 1'b0)
                $display("FAIL early_write: got rw=%b vld=%0b want 00/0", out_reg_write, out_valid); else n_pass++;
        end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_reg_write !== 2'b11) $display("FAIL early_captured_rw: got %b want 11", out_reg_write); else n_pass++;
        tick();
        n_checks++; if (out_reg_write !== 2'b00) $display("FAIL early_drained_rw: got %b want 00", out_reg_write); else n_pass++;
    endtask

    task automatic test_stall();
        bnd_t a;
        a = rnd_bundle();
        cur = a; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        cur = rnd_bundle();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (obs !== a || out_valid !== 1'b1)
                $display("FAIL stall_hold[%0d]: got %h/%0b want %h/1", k, obs, out_valid, a); else n_pass++;
            n_checks++; if (in_ready !== m_ready())
                $display("FAIL stall_in_ready[%0d]: got %0b want %0b", k, in_ready, m_ready()); else n_pass++;
            tick();
        end
        n_checks++; if (occupancy !== 2'(CAP)) $display("FAIL stall_occ: got %0d want %0d", occupancy, CAP); else n_pass++;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4 && mq.size() != 0; k++) begin
            #1;
            n_checks++; if (obs !== mq[0] || out_valid !== 1'b1)
                $display("FAIL stall_drain[%0d]: got %h want %h", k, obs, mq[0]); else n_pass++;
            tick();
        end
        n_checks++; if (occupancy !== 2'd0 || mq.size() != 0)
            $display("FAIL stall_empty: got %0d want 0", occupancy); else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < CAP; k++) begin
            cur = rnd_bundle();
            tick();
        end
        n_checks++; if (occupancy !== 2'(CAP)) $display("FAIL flush_pre_occ: got %0d want %0d", occupancy, CAP); else n_pass++;
        flush = 1'b1; cur = rnd_bundle(); cur.rw = 2'b11; out_ready = 1'($urandom);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_reg_write !== 2'b00) $display("FAIL flush_rw: got %b want 00", out_reg_write); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occupancy); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_input_lost: got %0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            in_valid = (sent < 16);
            cur = rnd_bundle();
            cur.rd[RD_W-1:0] = RD_W'(sent);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++; if (in_ready !== m_ready())
                $display("FAIL b2b_in_ready[%0d]: got %0b want %0b", cyc, in_ready, m_ready()); else n_pass++;
            n_checks++; if (out_valid !== (mq.size() != 0))
                $display("FAIL b2b_out_valid[%0d]: got %0b want %0b", cyc, out_valid, mq.size() != 0); else n_pass++;
            if (out_valid && out_ready && mq.size() != 0) begin
                n_checks++; if (obs !== mq[0] || obs.rd[RD_W-1:0] !== RD_W'(got))
                    $display("FAIL b2b_order: got rd %0d want %0d", obs.rd[RD_W-1:0], got); else n_pass++;
                got++;
            end
            if (in_valid && m_ready()) sent++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (got != 16) $display("FAIL b2b_count: got %0d want 16", got); else n_pass++;
    endtask

    task automatic test_async_reset();
        cur = rnd_bundle(); cur.rw = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #2;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL areset_pre_valid: got %0b want 1", out_valid); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL areset_occ: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (obs !== '0) $display("FAIL areset_fields: got %h want 0", obs); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready: got %0b want 1", in_ready); else n_pass++;
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_after: got %0b want 0", out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_early_write();
        test_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
